// File: rtl/fifo_wr_rr_arbiter.sv
// fifo_wr_rr_arbiter: round-robin arbiter sharing one synchronous FIFO write port
// among NUM_REQ producers, with the FIFO full flag as back-pressure.
// Optional burst-lock mode is enabled by defining the macro ARB_BURST_EN; the
// default build is plain per-beat round robin.
module fifo_wr_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 2,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [IDX_WIDTH-1:0]          last_id,
  output logic                          locked
);

  localparam int unsigned CNT_WIDTH = 8;

  // Reject parameter sets the index/beat logic cannot represent
  if (NUM_REQ < 2 || NUM_REQ > 16 || IDX_WIDTH < 1 || (1 << IDX_WIDTH) < NUM_REQ ||
      BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_param
    $error("fifo_wr_rr_arbiter: illegal parameter set");
  end

  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 win_vld;
  int                   scan_idx;

  // Successor index with an explicit wrap at NUM_REQ-1 (NUM_REQ need not be 2^n)
  function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] w);
    return (w == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : IDX_WIDTH'(w + IDX_WIDTH'(1));
  endfunction

`ifdef ARB_BURST_EN
  typedef enum logic {IDLE, LOCK} state_t;

  state_t               state;
  logic [IDX_WIDTH-1:0] owner;
  logic [CNT_WIDTH-1:0] beat_cnt;
`endif

  // Round-robin scan: first requester at or after rr_ptr, modulo NUM_REQ
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!win_vld && req[IDX_WIDTH'(scan_idx)]) begin
        win_vld = 1'b1;
        win_idx = IDX_WIDTH'(scan_idx);
      end
    end
  end

  // Combinational grant: nothing during reset or while the FIFO is full
  always_comb begin
    gnt = '0;
    if (!rst && !fifo_full) begin
`ifdef ARB_BURST_EN
      if (state == LOCK) begin
        if (req[owner]) gnt[owner] = 1'b1;
      end else if (win_vld) begin
        gnt[win_idx] = 1'b1;
      end
`else
      if (win_vld) gnt[win_idx] = 1'b1;
`endif
    end
  end

  // Write-data mux: OR of the (at most one) granted producer's word
  always_comb begin
    fifo_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) fifo_wdata = fifo_wdata | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_w_en = |gnt;

`ifdef ARB_BURST_EN
  // Pointer/lock state; everything freezes while the FIFO is full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      last_id  <= '0;
      state    <= IDLE;
      owner    <= '0;
      beat_cnt <= '0;
      locked   <= 1'b0;
    end else if (!fifo_full) begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            last_id <= win_idx;
            rr_ptr  <= next_idx(win_idx);
            if (BURST_LEN > 1) begin
              state    <= LOCK;
              owner    <= win_idx;
              beat_cnt <= CNT_WIDTH'(1);
              locked   <= 1'b1;
            end
          end
        end
        LOCK: begin
          if (!req[owner]) begin
            state    <= IDLE;
            locked   <= 1'b0;
            beat_cnt <= '0;
            rr_ptr   <= next_idx(owner);
          end else begin
            last_id <= owner;
            if (beat_cnt >= CNT_WIDTH'(BURST_LEN - 1)) begin
              state    <= IDLE;
              locked   <= 1'b0;
              beat_cnt <= '0;
              rr_ptr   <= next_idx(owner);
            end else begin
              beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end
`else
  // Per-beat pointer advance and last-winner capture on every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      last_id <= '0;
    end else if (!fifo_full && win_vld) begin
      rr_ptr  <= next_idx(win_idx);
      last_id <= win_idx;
    end
  end

  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// tb_fifo_wr_rr_arbiter: self-checking bench for fifo_wr_rr_arbiter.
// A 4-producer instance covers reset, rotation, back-pressure and (with
// ARB_BURST_EN) burst lock; a 3-producer instance covers the non-power-of-two
// wrap and end-to-end data integrity through a bench FIFO model.
module tb_fifo_wr_rr_arbiter;

  localparam int DW    = 8;
  localparam int NW    = 12;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]      req;
  logic [4*DW-1:0] req_data;
  logic [3:0]      gnt;
  logic            full;
  logic            w_en;
  logic [DW-1:0]   wdata;
  logic [1:0]      last_id;
  logic            locked;

  logic [2:0]      req3;
  logic [3*DW-1:0] req_data3;
  logic [2:0]      gnt3;
  logic            full3;
  logic            w_en3;
  logic [DW-1:0]   wdata3;
  logic [1:0]      last_id3;
  logic            locked3;

  fifo_wr_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW), .IDX_WIDTH(2), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(full), .fifo_w_en(w_en), .fifo_wdata(wdata),
    .last_id(last_id), .locked(locked)
  );

  fifo_wr_rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW), .IDX_WIDTH(2), .BURST_LEN(4)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_data(req_data3), .gnt(gnt3),
    .fifo_full(full3), .fifo_w_en(w_en3), .fifo_wdata(wdata3),
    .last_id(last_id3), .locked(locked3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard state for the data-integrity run
  logic [7:0] exp_q [3][$];
  logic [7:0] mfifo [$];
  int         seq  [3];
  bit         pend [3];
  logic [7:0] word [3];

`ifdef ARB_BURST_EN
  logic [3:0] eg [10] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001,
                          4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
  bit         el [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
  bit         fp [10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
`endif

  initial begin
    logic [3:0] e4;
    logic [7:0] popped;
    logic [7:0] acc_word;
    int         gid;
    int         pid;
    int         received;
    bit         drain;
    bit         accepted;
    bit         done;

    rst       = 1'b1;
    req       = '0;
    full      = 1'b0;
    req3      = '0;
    req_data3 = '0;
    full3     = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = 8'(8'hA0 + i);

    // Reset holds everything quiet even with all producers requesting
    @(negedge clk);
    req = 4'b1111;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_wen", 32'(w_en), 32'h0);
    check("rst_wdata", 32'(wdata), 32'h0);
    check("rst_last_id", 32'(last_id), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

`ifndef ARB_BURST_EN
    // Rotation with all four requesting
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      e4 = 4'(1 << (c % 4));
      check("rot_gnt", 32'(gnt), 32'(e4));
      check("rot_wdata", 32'(wdata), 32'(8'hA0 + (c % 4)));
      @(posedge clk);
      #1;
      check("rot_last_id", 32'(last_id), 32'(c % 4));
    end

    // Back-pressure: pointer (=2) and last_id (=1) hold while full
    full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("bp_gnt", 32'(gnt), 32'h0);
      check("bp_wen", 32'(w_en), 32'h0);
      check("bp_wdata", 32'(wdata), 32'h0);
      @(posedge clk);
      #1;
      check("bp_last_id", 32'(last_id), 32'd1);
    end
    full = 1'b0;
    @(negedge clk);
    check("bp_resume_gnt", 32'(gnt), 32'b0100);
    @(posedge clk);
    #1;
    check("bp_resume_last_id", 32'(last_id), 32'd2);

    // Asynchronous reset asserted mid-cycle clears at once
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_last_id", 32'(last_id), 32'h0);
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_wen", 32'(w_en), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("arst_restart_gnt", 32'(gnt), 32'b0001);
    @(posedge clk);
    #1;
    req  = '0;
    req3 = 3'b101;
    for (int i = 0; i < 3; i++) req_data3[i*DW +: DW] = 8'(8'h30 + i);

    // Wrap with three producers: 0, then 2, then back to 0
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("wrap_gnt", 32'(gnt3), (c == 1) ? 32'b100 : 32'b001);
      check("wrap_wdata", 32'(wdata3), (c == 1) ? 32'h32 : 32'h30);
      @(posedge clk);
      #1;
      check("wrap_last_id", 32'(last_id3), (c == 1) ? 32'd2 : 32'd0);
    end
    req3 = '0;
`else
    // Burst lock: four beats to 0 (one stall inside), then four to 1
    req = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      full = fp[c];
      @(negedge clk);
      check("burst_gnt", 32'(gnt), 32'(eg[c]));
      check("burst_locked", 32'(locked), 32'(el[c]));
      @(posedge clk);
      #1;
    end
    req  = '0;
    full = 1'b0;
`endif

    // Clean restart before the data-integrity run
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Three producers into a depth-8 FIFO model drained at random
    for (int i = 0; i < 3; i++) begin
      seq[i]  = 0;
      pend[i] = 1'b0;
      word[i] = '0;
    end
    mfifo.delete();
    received = 0;
    done     = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && seq[i] < NW && $urandom_range(0, 2) != 0) begin
          word[i] = {2'(i), 6'(seq[i])};
          pend[i] = 1'b1;
          exp_q[i].push_back(word[i]);
          req3[i] = 1'b1;
        end else if (pend[i]) begin
          req3[i] = ($urandom_range(0, 7) != 0);
        end else begin
          req3[i] = 1'b0;
        end
        req_data3[i*DW +: DW] = pend[i] ? word[i] : 8'h00;
      end
      full3 = (mfifo.size() == DEPTH);

      @(negedge clk);
      check("int_onehot", 32'($onehot0(gnt3)), 32'd1);
      check("int_gnt_req", 32'(gnt3 & ~req3), 32'h0);
      check("int_wen", 32'(w_en3), 32'((req3 != '0) && !full3));
      accepted = w_en3;
      acc_word = wdata3;
      gid      = 0;
      for (int i = 0; i < 3; i++) if (gnt3[i]) gid = i;
      if (accepted) check("int_wdata", 32'(acc_word), 32'(word[gid]));
      drain = ($urandom_range(0, 99) < 40);

      @(posedge clk);
      #1;
      if (drain && mfifo.size() > 0) begin
        popped = mfifo.pop_front();
        pid    = int'(popped[7:6]);
        received++;
        if (pid > 2 || exp_q[pid].size() == 0) check("int_unexpected", 32'(popped), 32'hFFFF_FFFF);
        else check("int_order", 32'(popped), 32'(exp_q[pid].pop_front()));
      end
      if (accepted) begin
        mfifo.push_back(acc_word);
        pend[gid] = 1'b0;
        seq[gid]++;
        req3[gid] = 1'b0;
      end
      done = (mfifo.size() == 0);
      for (int i = 0; i < 3; i++) if (pend[i] || seq[i] < NW) done = 1'b0;
    end
    req3 = '0;
    check("int_received", 32'(received), 32'(3 * NW));
    for (int i = 0; i < 3; i++) check("int_leftover", 32'(exp_q[i].size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
